noc_inject_port: RTL and testbench

NOC_INJECT_PORT -- requirements
Module: noc_inject_port

---
 rtl/noc_pkg.sv | 39 +++
 rtl/noc_pkt_fifo.sv | 61 ++++++
 rtl/noc_inject_port.sv | 184 ++++++++++++++++++
 tb/tb_noc_inject_port.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_pkg
// Description : Shared constants, packet field offsets, flit flags and the
//               serializer state encoding for the NoC injection port.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

    // Packet geometry for the default filter element width
    localparam int c_FILTER_WIDTH = 8;
    localparam int c_PKT_W        = 5 * c_FILTER_WIDTH + 13;

    // Flit geometry: one flag bit above the payload
    localparam int   c_FLIT_W   = 28;
    localparam int   c_FLAG_BIT = 27;
    localparam logic c_HEAD_FLAG = 1'b1;
    localparam logic c_TAIL_FLAG = 1'b0;

    // The head carries pkt[26:0]; the tail carries everything from bit 27 up
    localparam int c_TAIL_LSB = 27;

    // Control-unit packet bit-field offsets
    localparam int c_DIR_LSB  = 0;   // [1:0] direction
    localparam int c_XHOP_LSB = 2;   // [4:2] x-hop
    localparam int c_YHOP_LSB = 5;   // [7:5] y-hop
    localparam int c_TS_BIT   = 8;   // [8]   timestep
    localparam int c_KIND_BIT = 9;   // [9]   ifmap(0)/filter(1)
    localparam int c_DATA_LSB = 10;  // [PKT_W-1:10] row/location/data

    // Serializer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_TAIL = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/noc_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : noc_pkt_fifo
// Description : Synchronous whole-packet FIFO with registered occupancy.
//               DEPTH must be a power of two (pointers wrap naturally).
//               The caller never pushes when full nor pops when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_pkt_fifo #(
    parameter int WIDTH = 53,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    // Storage array: written on push, no reset needed for the payload
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves count unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rdata = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/noc_inject_port.sv
`default_nettype none
// ============================================================================
// Module      : noc_inject_port
// Description : Buffers control-unit packets and serializes each one into a
//               head and a tail flit toward a credit-flow-controlled router.
//               Define NOC_INJECT_STATS_EN to add the pkt_sent_cnt output.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_inject_port
    import noc_pkg::*;
#(
    parameter int FILTER_WIDTH = 8,
    parameter int PKT_W        = 5 * FILTER_WIDTH + 13,
    parameter int FIFO_DEPTH   = 4,
    parameter int CREDITS      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pkt_valid,
    output logic                pkt_ready,
    input  logic [PKT_W-1:0]    pkt_data,
    output logic                flit_valid,
    output logic [c_FLIT_W-1:0] flit_data,
    input  logic                credit_return,
    output logic                credit_err
`ifdef NOC_INJECT_STATS_EN
    ,
    output logic [15:0]         pkt_sent_cnt
`endif
);
    localparam int c_CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int c_CRD_W  = $clog2(CREDITS + 1);
    localparam int c_TAIL_W = c_FLIT_W - 1;
    localparam logic [c_CNT_W-1:0] c_FIFO_FULL = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_CRD_W-1:0] c_CRD_MAX   = c_CRD_W'(CREDITS);

    state_t              r_state;
    state_t              w_state_nx;
    logic                r_live;
    logic [c_CNT_W-1:0]  w_count;
    logic [PKT_W-1:0]    w_front;
    logic                w_push;
    logic                w_pending;
    logic                w_has_credit;
    logic                w_send_head;
    logic                w_send_tail;
    logic                w_send;
    logic [c_CRD_W-1:0]  r_credit;
    logic                r_credit_err;
    logic                r_flit_valid;
    logic [c_FLIT_W-1:0] r_flit_data;
    logic [c_FLIT_W-1:0] w_head_flit;
    logic [c_FLIT_W-1:0] w_tail_flit;

    // Ready is held low during reset and comes up on the first edge after it
    assign pkt_ready    = r_live & (w_count < c_FIFO_FULL);
    assign w_push       = pkt_valid & pkt_ready;
    assign w_pending    = (w_count != '0);
    assign w_has_credit = (r_credit != '0);
    assign w_send       = w_send_head | w_send_tail;

    // The packet under serialization stays at the FIFO front until its tail goes
    assign w_head_flit = {c_HEAD_FLAG, w_front[c_TAIL_LSB-1:0]};
    assign w_tail_flit = {c_TAIL_FLAG, c_TAIL_W'(w_front[PKT_W-1:c_TAIL_LSB])};

    noc_pkt_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_send_tail),
        .wdata (pkt_data),
        .rdata (w_front),
        .count (w_count)
    );

    // Ready-enable: set on the first clock edge out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    // Serializer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next state and send decisions; a flit is issued on the edge that leaves
    // the deciding state, so HEAD shows the head flit and TAIL either waits for
    // a credit (flit_valid low) or shows the tail flit just issued.
    always_comb begin
        w_state_nx  = r_state;
        w_send_head = 1'b0;
        w_send_tail = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pending && w_has_credit) begin
                    w_send_head = 1'b1;
                    w_state_nx  = ST_HEAD;
                end
            end
            ST_HEAD: begin
                w_state_nx  = ST_TAIL;
                w_send_tail = w_has_credit;
            end
            ST_TAIL: begin
                if (!r_flit_valid) begin
                    w_send_tail = w_has_credit;
                end else if (w_pending && w_has_credit) begin
                    w_send_head = 1'b1;
                    w_state_nx  = ST_HEAD;
                end else begin
                    w_state_nx  = ST_IDLE;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // Registered flit outputs; data holds its last value between flits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flit_valid <= 1'b0;
            r_flit_data  <= '0;
        end else begin
            r_flit_valid <= w_send;
            if (w_send_head) begin
                r_flit_data <= w_head_flit;
            end else if (w_send_tail) begin
                r_flit_data <= w_tail_flit;
            end
        end
    end

    // Credit counter: send and return together cancel; overflow saturates and sticks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credit     <= c_CRD_MAX;
            r_credit_err <= 1'b0;
        end else begin
            if (w_send && !credit_return) begin
                r_credit <= r_credit - c_CRD_W'(1);
            end else if (!w_send && credit_return) begin
                if (r_credit == c_CRD_MAX) begin
                    r_credit_err <= 1'b1;
                end else begin
                    r_credit <= r_credit + c_CRD_W'(1);
                end
            end
        end
    end

    assign flit_valid = r_flit_valid;
    assign flit_data  = r_flit_data;
    assign credit_err = r_credit_err;

`ifdef NOC_INJECT_STATS_EN
    logic [15:0] r_pkt_sent_cnt;

    // Completed-packet counter, advanced on each tail flit and wrapping at 16 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pkt_sent_cnt <= 16'd0;
        end else if (w_send_tail) begin
            r_pkt_sent_cnt <= r_pkt_sent_cnt + 16'd1;
        end
    end

    assign pkt_sent_cnt = r_pkt_sent_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_noc_inject_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_inject_port
// Description : Self-checking bench for noc_inject_port. A packet-level model
//               (queue of packets, credit count, in-flight flag) predicts the
//               outputs after every clock edge; literal checks pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_inject_port;
    localparam int FIFO_DEPTH = 4;
    localparam int CREDITS    = 4;
    localparam int PKT_W      = 53;

    logic             clk           = 1'b0;
    logic             rst           = 1'b0;
    logic             pkt_valid     = 1'b0;
    logic             credit_return = 1'b0;
    logic [PKT_W-1:0] pkt_data      = '0;
    logic             pkt_ready;
    logic             flit_valid;
    logic [27:0]      flit_data;
    logic             credit_err;
`ifdef NOC_INJECT_STATS_EN
    logic [15:0]      pkt_sent_cnt;
`endif

    int n_cmp   = 0;
    int n_bad   = 0;
    int n_flits = 0;

    // Packet-level model state
    logic [PKT_W-1:0] m_q[$];
    int               m_credit;
    bit               m_inflight;
    bit               m_err;
    bit               m_live;
    bit               m_fv;
    bit               m_pushed;
    bit               echo;
    logic [27:0]      m_flit;

    noc_inject_port #(
        .FILTER_WIDTH (8),
        .PKT_W        (PKT_W),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .CREDITS      (CREDITS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pkt_valid     (pkt_valid),
        .pkt_ready     (pkt_ready),
        .pkt_data      (pkt_data),
        .flit_valid    (flit_valid),
        .flit_data     (flit_data),
        .credit_return (credit_return),
        .credit_err    (credit_err)
`ifdef NOC_INJECT_STATS_EN
        ,
        .pkt_sent_cnt  (pkt_sent_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got still running, expected finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_credit   = CREDITS;
        m_inflight = 1'b0;
        m_err      = 1'b0;
        m_live     = 1'b0;
        m_fv       = 1'b0;
        m_flit     = '0;
    endtask

    task automatic compare_all();
        check("pkt_ready",  pkt_ready,  m_live && (m_q.size() < FIFO_DEPTH));
        check("flit_valid", flit_valid, m_fv);
        check("flit_data",  flit_data,  m_flit);
        check("credit_err", credit_err, m_err);
    endtask

    // One clock: model the edge from the current inputs, then compare after it
    task automatic step();
        bit               rdy;
        bit               sh;
        bit               st;
        logic [PKT_W-1:0] front;
        m_pushed = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            rdy = m_live && (m_q.size() < FIFO_DEPTH);
            sh  = !m_inflight && (m_q.size() > 0) && (m_credit > 0);
            st  = m_inflight && (m_credit > 0);
            if (echo) credit_return = sh || st;
            m_fv = sh || st;
            if (sh) begin
                m_flit     = {1'b1, m_q[0][26:0]};
                m_inflight = 1'b1;
            end
            if (st) begin
                front      = m_q.pop_front();
                m_flit     = {2'b00, front[52:27]};
                m_inflight = 1'b0;
            end
            if (credit_return && !m_fv && m_credit == CREDITS) m_err = 1'b1;
            else m_credit = m_credit - int'(m_fv) + int'(credit_return);
            if (pkt_valid && rdy) begin
                m_q.push_back(pkt_data);
                m_pushed = 1'b1;
            end
            m_live = 1'b1;
        end
        @(posedge clk);
        #1;
        if (flit_valid === 1'b1) n_flits++;
        compare_all();
    endtask

    task automatic offer(input int cycles, input logic [PKT_W-1:0] base);
        logic [PKT_W-1:0] d;
        d = base;
        for (int i = 0; i < cycles; i++) begin
            pkt_valid = 1'b1;
            pkt_data  = d;
            step();
            if (m_pushed) d = d + 53'h03_0000_0C00_0001;
        end
        pkt_valid = 1'b0;
    endtask

    task automatic assert_reset();
        rst           = 1'b1;
        pkt_valid     = 1'b0;
        credit_return = 1'b0;
        echo          = 1'b0;
        model_reset();
        #1;
        compare_all();
    endtask

    initial begin
        echo = 1'b0;
        model_reset();
        #2;
        // Reset values, checked while reset is held
        assert_reset();
        check("rst_pkt_ready",  pkt_ready,  1'b0);
        check("rst_flit_valid", flit_valid, 1'b0);
        check("rst_flit_data",  flit_data,  28'h0);
        check("rst_credit_err", credit_err, 1'b0);
        step();
        step();
        rst = 1'b0;
        step();
        check("ready_after_release", pkt_ready, 1'b1);

        // Single packet: head at N+1, tail at N+2
        pkt_valid = 1'b1;
        pkt_data  = 53'h1A_2B3C_4D5E_6F70;
        step();
        pkt_valid = 1'b0;
        step();
        check("single_head_valid", flit_valid, 1'b1);
        check("single_head_data",  flit_data,  28'hD5E6F70);
        step();
        check("single_tail_valid", flit_valid, 1'b1);
        check("single_tail_data",  flit_data,  28'h3456789);
        step();
        check("single_idle_valid", flit_valid, 1'b0);
        check("single_idle_hold",  flit_data,  28'h3456789);
        credit_return = 1'b1;
        step();
        step();
        credit_return = 1'b0;

        // Credit returned with every send: eight flits flow back to back
        echo    = 1'b1;
        n_flits = 0;
        offer(4, 53'h00_1111_2222_3333);
        repeat (6) step();
        echo          = 1'b0;
        credit_return = 1'b0;
        check("echo_flits", n_flits, 8);
        check("echo_err",   credit_err, 1'b0);

        // No credit return: four flits, then stall with the FIFO full
        n_flits = 0;
        offer(8, 53'h05_4444_5555_6666);
        check("full_ready",  pkt_ready, 1'b0);
        check("stall_flits", n_flits, 4);
        repeat (3) step();
        check("stall_idle", flit_valid, 1'b0);

        // One credit: head goes, tail waits in TAIL until the next credit
        credit_return = 1'b1;
        step();
        credit_return = 1'b0;
        step();
        check("wait_head_valid", flit_valid, 1'b1);
        check("wait_head_flag",  flit_data[27], 1'b1);
        repeat (3) step();
        check("wait_in_tail", flit_valid, 1'b0);
        credit_return = 1'b1;
        step();
        credit_return = 1'b0;
        check("wait_pulse_edge", flit_valid, 1'b0);
        step();
        check("wait_tail_valid", flit_valid, 1'b1);
        check("wait_tail_flag",  flit_data[27], 1'b0);

        // Reset while waiting in TAIL discards everything
        credit_return = 1'b1;
        step();
        credit_return = 1'b0;
        step();
        step();
        n_flits = 0;
        assert_reset();
        check("rst_tail_valid", flit_valid, 1'b0);
        check("rst_tail_ready", pkt_ready,  1'b0);
        step();
        step();
        rst = 1'b0;
        step();
        step();
        step();
        check("rst_no_tail", n_flits, 0);
        pkt_valid = 1'b1;
        pkt_data  = {26'h1234567, 27'h0ABCDEF};
        step();
        pkt_valid = 1'b0;
        step();
        check("post_rst_head_valid", flit_valid, 1'b1);
        check("post_rst_head_data",  flit_data,  28'h8ABCDEF);
        step();
        check("post_rst_tail_data",  flit_data,  28'h1234567);

        // Credit return with a full count and nothing sent: sticky error, count saturated
        assert_reset();
        step();
        rst = 1'b0;
        step();
        credit_return = 1'b1;
        step();
        credit_return = 1'b0;
        check("sat_err", credit_err, 1'b1);
        repeat (3) step();
        check("sat_err_sticky", credit_err, 1'b1);
        n_flits = 0;
        offer(3, 53'h0A_7777_8888_9999);
        repeat (8) step();
        check("sat_flits",    n_flits, 4);
        check("sat_err_hold", credit_err, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
